// File: rtl/ev22_pkg.sv
// Shared ev22 datapath types and widths used by decode, writeback and the register file.
package ev22_pkg;

    localparam int unsigned EV22_DATA_WIDTH = 32;
    localparam int unsigned EV22_ADDR_WIDTH = 5;
    localparam int unsigned EV22_REG_ZERO   = 0;

    typedef logic [EV22_DATA_WIDTH-1:0] reg_data_t;
    typedef logic [EV22_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: index mux, zero-register override, optional write forwarding
// (REGFILE_BYPASS_EN) and an output register that holds while re is low.
module regfile_read_port
    import ev22_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = EV22_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = EV22_ADDR_WIDTH,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH],
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] rd_c;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

`ifndef REGFILE_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_en, waddr, wdata};
`endif

    always_comb begin
        rd_c = mem[raddr];
`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes discarded zero-register writes
        if (wr_en && (raddr == waddr)) begin
            rd_c = wdata;
        end
`endif
        if ((ZERO_REG != 0) && (raddr == ADDR_WIDTH'(EV22_REG_ZERO))) begin
            rd_c = '0;
        end
        rdata_d = re ? rd_c : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/regfile_2r1w.sv
// ev22 general-purpose register file, one write port and two registered read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read.
module regfile_2r1w
    import ev22_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = EV22_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = EV22_ADDR_WIDTH,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  rvalid
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_en_c;
    logic                  rvalid_d;
    logic                  rvalid_q;

    // Writes to the hardwired zero register are dropped here, not at the read side
    always_comb begin
        wr_en_c = we && !((ZERO_REG != 0) && (waddr == ADDR_WIDTH'(EV22_REG_ZERO)));
        mem_d   = mem_q;
        if (wr_en_c) begin
            mem_d[waddr] = wdata;
        end
        rvalid_d = re;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rvalid_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rvalid_q <= rvalid_d;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_port_a (
        .clk   (clk),
        .reset (reset),
        .re    (re),
        .raddr (raddr_a),
        .mem   (mem_q),
        .wr_en (wr_en_c),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata_a)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_port_b (
        .clk   (clk),
        .reset (reset),
        .re    (re),
        .raddr (raddr_b),
        .mem   (mem_q),
        .wr_en (wr_en_c),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata_b)
    );

    assign rvalid = rvalid_q;

endmodule
